line_refill_ctrl: RTL and testbench

//  Line-refill engine between the direct-mapped instruction/data cache and the 32-bit main-memory bus.

---
 rtl/line_refill_pkg.sv | 24 ++
 rtl/line_refill_ctrl.sv | 133 +++++++++++++
 tb/tb_line_refill_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_refill_pkg.sv
// Shared types and geometry for the cache line-refill engine.
// The line size is derived from NrWordsPerLine, so changing that one constant resizes the whole engine.
package line_refill_pkg;

   localparam int NrWordsPerLine = 4;
   localparam int LineSize       = 32 * NrWordsPerLine;
   localparam int WordIdxBits    = $clog2(NrWordsPerLine);
   localparam int OffsetBits     = WordIdxBits + 2;

   localparam logic [WordIdxBits-1:0] LastWordIdx = WordIdxBits'(NrWordsPerLine - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RESP
   } refill_state_e;

   // Clears the byte-in-line offset bits so the address points at the first byte of its line.
   function automatic logic [31:0] align_line(input logic [31:0] addr);
      return {addr[31:OffsetBits], {OffsetBits{1'b0}}};
   endfunction

endpackage

// File: rtl/line_refill_ctrl.sv
// Line-refill engine: turns one line-aligned cache miss into NrWordsPerLine single-word bus reads.
// Optional macro LINE_REFILL_LINE_BUF_EN: when the last completed line is requested again, the stored line is returned without bus reads.
module line_refill_ctrl
   import line_refill_pkg::*;
(
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [31:0]         mem_addr_i,
   input  logic                mem_read_en_i,
   output logic                mem_read_valid_o,
   output logic [LineSize-1:0] mem_read_data_o,
   output logic                bus_req_o,
   output logic [31:0]         bus_addr_o,
   input  logic                bus_gnt_i,
   input  logic                bus_rvalid_i,
   input  logic [31:0]         bus_rdata_i
);

   refill_state_e          r_state;
   refill_state_e          w_state_nxt;
   logic [31:0]            r_base;
   logic [WordIdxBits-1:0] r_cnt;
   logic [LineSize-1:0]    r_data;
   logic                   r_drop;

   logic w_start;
   logic w_store;
   logic w_abort;
   logic w_done;
   logic w_busy;
   logic w_hit;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case statement, so no path leaves one unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_store     = 1'b0;
      w_abort     = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (mem_read_en_i) begin
               if (w_hit) begin
                  w_state_nxt = RESP;
               end else begin
                  w_start     = 1'b1;
                  w_state_nxt = REQ;
               end
            end
         end
         REQ: begin
            if (bus_gnt_i) w_state_nxt = WAIT;
         end
         WAIT: begin
            if (bus_rvalid_i) begin
               w_store = 1'b1;
               if (r_drop || !mem_read_en_i) begin
                  w_abort     = 1'b1;
                  w_state_nxt = IDLE;
               end else if (r_cnt == LastWordIdx) begin
                  w_done      = 1'b1;
                  w_state_nxt = RESP;
               end else begin
                  w_state_nxt = REQ;
               end
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_busy = (r_state == REQ) || (r_state == WAIT);

   // NOTE: the line register is reset because an all-zero line is the defined output after reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_base <= '0;
         r_cnt  <= '0;
         r_data <= '0;
         r_drop <= 1'b0;
      end else begin
         if (w_start) begin
            r_base <= align_line(mem_addr_i);
            r_cnt  <= '0;
         end else if (w_store) begin
            r_data[{r_cnt, 5'd0} +: 32] <= bus_rdata_i;
            r_cnt                       <= r_cnt + 1'b1;
         end
         // The cache withdrew its request: finish the bus read in flight, then stop.
         if (w_start || w_abort) begin
            r_drop <= 1'b0;
         end else if (w_busy && !mem_read_en_i) begin
            r_drop <= 1'b1;
         end
      end
   end

`ifdef LINE_REFILL_LINE_BUF_EN
   logic [31:0] r_buf_addr;
   logic        r_buf_vld;

   assign w_hit = r_buf_vld && (r_buf_addr == align_line(mem_addr_i));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_buf_addr <= '0;
         r_buf_vld  <= 1'b0;
      end else if (w_done) begin
         r_buf_addr <= r_base;
         r_buf_vld  <= 1'b1;
      end else if (w_abort) begin
         r_buf_vld  <= 1'b0;
      end
   end
`else
   assign w_hit = 1'b0;
`endif

   assign bus_req_o        = (r_state == REQ);
   assign bus_addr_o       = r_base + {{(30 - WordIdxBits){1'b0}}, r_cnt, 2'b00};
   assign mem_read_valid_o = (r_state == RESP);
   assign mem_read_data_o  = r_data;

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Directed bench for line_refill_ctrl: a bus slave model with an optional grant stall, plus one task per scenario.
// The line-buffer scenario is compiled only when LINE_REFILL_LINE_BUF_EN is defined.
module tb_line_refill_ctrl;
   import line_refill_pkg::*;

   logic                clk_i = 1'b0;
   logic                rstn_i;
   logic [31:0]         mem_addr_i;
   logic                mem_read_en_i;
   logic                mem_read_valid_o;
   logic [LineSize-1:0] mem_read_data_o;
   logic                bus_req_o;
   logic [31:0]         bus_addr_o;
   logic                bus_gnt_i;
   logic                bus_rvalid_i;
   logic [31:0]         bus_rdata_i;

   int n_cmp = 0;
   int n_err = 0;

   int          cyc = 0;
   int          start_cyc;
   int          pulse_cnt = 0;
   int          pulse_cyc = 0;
   int          gnt_cnt = 0;
   int          req_cycles = 0;
   logic [31:0] gnt_log[$];
   logic [31:0] data_base = 32'h0;
   logic [31:0] stall_addr = 32'h0;
   int          stall_left = 0;
   int          stall_seen = 0;
   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;

   line_refill_ctrl u_dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .mem_addr_i       (mem_addr_i),
      .mem_read_en_i    (mem_read_en_i),
      .mem_read_valid_o (mem_read_valid_o),
      .mem_read_data_o  (mem_read_data_o),
      .bus_req_o        (bus_req_o),
      .bus_addr_o       (bus_addr_o),
      .bus_gnt_i        (bus_gnt_i),
      .bus_rvalid_i     (bus_rvalid_i),
      .bus_rdata_i      (bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Bus slave and pulse monitor: grants on the negedge, returns data one cycle after the grant.
   always @(negedge clk_i) begin
      if (!rstn_i) begin
         pend         = 1'b0;
         bus_gnt_i    = 1'b0;
         bus_rvalid_i = 1'b0;
         bus_rdata_i  = 32'hDEAD_BEEF;
      end else begin
         bus_rvalid_i = pend;
         bus_rdata_i  = pend ? data_base + ((pend_addr >> 2) & 32'h3) : 32'hDEAD_BEEF;
         pend         = 1'b0;
         bus_gnt_i    = 1'b0;
         if (bus_req_o) begin
            req_cycles++;
            if (stall_left > 0 && bus_addr_o == stall_addr) begin
               stall_left--;
               stall_seen++;
            end else begin
               bus_gnt_i = 1'b1;
               pend      = 1'b1;
               pend_addr = bus_addr_o;
               gnt_cnt++;
               gnt_log.push_back(bus_addr_o);
            end
         end
         if (mem_read_valid_o) begin
            pulse_cnt++;
            pulse_cyc = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [LineSize-1:0] mk_line(input logic [31:0] b);
      logic [LineSize-1:0] l;
      l = '0;
      for (int k = 0; k < NrWordsPerLine; k++) l[32*k +: 32] = b + 32'(k);
      return l;
   endfunction

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic start_req(input logic [31:0] a);
      mem_addr_i    = a;
      mem_read_en_i = 1'b1;
      start_cyc     = cyc;
   endtask

   task automatic wait_pulse(input string name);
      int  p0;
      bit  ok;
      p0 = pulse_cnt;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (pulse_cnt != p0) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s_timeout: no valid pulse within 60 cycles", name);
      end
   endtask

   task automatic check_line(input string name, input logic [LineSize-1:0] exp);
      n_cmp++;
      if (mem_read_data_o !== exp) begin
         n_err++;
         $display("FAIL %s_data: got %h expected %h", name, mem_read_data_o, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_addrs(input string name, input int g0, input logic [31:0] base);
      for (int k = 0; k < NrWordsPerLine; k++) begin
         n_cmp++;
         if (g0 + k >= gnt_log.size()) begin
            n_err++;
            $display("FAIL %s_addr%0d: no grant recorded, expected %h", name, k, base + 32'(4*k));
         end else if (gnt_log[g0+k] !== base + 32'(4*k)) begin
            n_err++;
            $display("FAIL %s_addr%0d: got %h expected %h", name, k, gnt_log[g0+k], base + 32'(4*k));
         end
      end
   endtask

   task automatic test_reset();
      rstn_i        = 1'b0;
      mem_addr_i    = 32'h0;
      mem_read_en_i = 1'b0;
      tick();
      tick();
      check_int("reset_valid", int'(mem_read_valid_o), 0);
      check_int("reset_req", int'(bus_req_o), 0);
      check_int("reset_addr", int'(bus_addr_o), 0);
      check_line("reset", '0);
      rstn_i = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int g0;
      int r0;
      data_base = 32'hA0;
      g0 = gnt_cnt;
      r0 = req_cycles;
      start_req(32'h0000_1234);
      wait_pulse("single");
      mem_read_en_i = 1'b0;
      check_int("single_latency", pulse_cyc - start_cyc, 9);
      check_addrs("single", g0, 32'h1230);
      check_int("single_req_cycles", req_cycles - r0, 4);
      check_line("single", {32'hA3, 32'hA2, 32'hA1, 32'hA0});
      tick();
      check_int("single_pulse_width", int'(mem_read_valid_o), 0);
      tick();
   endtask

   task automatic test_back_to_back();
      int resp_cyc;
      int p0;
      int g1;
      data_base = 32'h10;
      p0 = pulse_cnt;
      start_req(32'h0000_1000);
      wait_pulse("b2b_first");
      resp_cyc   = pulse_cyc;
      check_line("b2b_first", mk_line(32'h10));
      mem_addr_i = 32'h0000_2000;
      data_base  = 32'h20;
      g1 = gnt_cnt;
      wait_pulse("b2b_second");
      mem_read_en_i = 1'b0;
      check_int("b2b_latency", pulse_cyc - resp_cyc, 10);
      check_addrs("b2b", g1, 32'h2000);
      check_line("b2b_second", mk_line(32'h20));
      tick();
      tick();
      tick();
      check_int("b2b_pulse_count", pulse_cnt - p0, 2);
   endtask

   task automatic test_gnt_stall();
      int g0;
      data_base  = 32'hB0;
      stall_addr = 32'h1238;
      stall_left = 3;
      stall_seen = 0;
      g0 = gnt_cnt;
      start_req(32'h0000_1234);
      wait_pulse("stall");
      mem_read_en_i = 1'b0;
      check_int("stall_latency", pulse_cyc - start_cyc, 12);
      check_int("stall_held_cycles", stall_seen, 3);
      check_addrs("stall", g0, 32'h1230);
      check_line("stall", mk_line(32'hB0));
      tick();
   endtask

   task automatic test_drop();
      int g0;
      int p0;
      int r0;
      data_base = 32'h30;
      g0 = gnt_cnt;
      p0 = pulse_cnt;
      start_req(32'h0000_3000);
      for (int i = 0; i < 40 && gnt_cnt < g0 + 2; i++) tick();
      mem_read_en_i = 1'b0;
      r0 = req_cycles;
      for (int i = 0; i < 12; i++) tick();
      check_int("drop_grants", gnt_cnt - g0, 2);
      check_int("drop_req_after", req_cycles - r0, 0);
      check_int("drop_no_pulse", pulse_cnt - p0, 0);
      check_int("drop_word1", int'(mem_read_data_o[63:32]), 32'h31);
      check_int("drop_idle_req", int'(bus_req_o), 0);
   endtask

   task automatic test_reset_mid();
      int g0;
      data_base = 32'h40;
      g0 = gnt_cnt;
      start_req(32'h0000_4000);
      for (int i = 0; i < 40 && gnt_cnt == g0; i++) tick();
      tick();
      rstn_i = 1'b0;
      #1;
      check_int("rstmid_valid", int'(mem_read_valid_o), 0);
      check_int("rstmid_req", int'(bus_req_o), 0);
      check_int("rstmid_addr", int'(bus_addr_o), 0);
      check_line("rstmid", '0);
      mem_read_en_i = 1'b0;
      tick();
      tick();
      rstn_i = 1'b1;
      tick();
      data_base = 32'h50;
      g0 = gnt_cnt;
      start_req(32'h0000_0000);
      wait_pulse("rstmid_refill");
      mem_read_en_i = 1'b0;
      check_int("rstmid_latency", pulse_cyc - start_cyc, 9);
      check_addrs("rstmid", g0, 32'h0);
      check_line("rstmid_refill", mk_line(32'h50));
      tick();
   endtask

`ifdef LINE_REFILL_LINE_BUF_EN
   task automatic test_line_buf();
      int r0;
      data_base = 32'h60;
      start_req(32'h0000_1230);
      wait_pulse("lbuf_fill");
      mem_read_en_i = 1'b0;
      tick();
      data_base = 32'h70;
      r0 = req_cycles;
      start_req(32'h0000_1234);
      wait_pulse("lbuf_hit");
      mem_read_en_i = 1'b0;
      check_int("lbuf_latency", pulse_cyc - start_cyc, 1);
      check_int("lbuf_no_req", req_cycles - r0, 0);
      check_line("lbuf_hit", mk_line(32'h60));
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gnt_stall();
      test_drop();
      test_reset_mid();
`ifdef LINE_REFILL_LINE_BUF_EN
      test_line_buf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
